// File: rtl/mem_system.sv
// Memory-side responder for the 8-bit core: streams a program into imem,
// runs the core until pc stops moving, then freezes dmem for host readback.
//
// state  | meaning
// S_LOAD | core held in reset, host streams program words into imem
// S_RUN  | core released, dmem writable, watching pc for a self-loop
// S_DONE | core held in reset, dmem frozen for debug readback
module mem_system #(
    parameter int IMEM_DEPTH  = 256,
    parameter int DMEM_DEPTH  = 256,
    parameter int HALT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [8:0] ld_data,
    input  logic       ld_last,
    input  logic [7:0] pc,
    output logic [8:0] inst,
    input  logic       MemWrite,
    input  logic [7:0] ALUOut,
    input  logic [7:0] SrcA,
    output logic [7:0] ReadData,
    output logic       core_rst,
    output logic       done,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic [8:0] ld_count
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [8:0] ld_count_next;
    logic [3:0] halt_cnt, halt_cnt_next;
    logic [7:0] pc_prev;
    logic       pc_prev_valid;

    logic [8:0] imem [IMEM_DEPTH];
    logic [7:0] dmem [DMEM_DEPTH];

    logic ld_accept;
    logic ld_final;
    logic pc_repeat;
    logic halt_hit;
    logic dmem_we;

    // ld_ready is qualified by rst so nothing is offered while reset is held.
    assign ld_ready  = (state == S_LOAD) && rst;
    assign ld_accept = ld_ready && ld_valid;
    assign ld_final  = ld_last || (ld_count == 9'(IMEM_DEPTH - 1));

    assign pc_repeat = pc_prev_valid && (pc == pc_prev);
    assign halt_hit  = (state == S_RUN) && pc_repeat &&
                       (halt_cnt == 4'(HALT_CYCLES - 1));

    assign dmem_we   = (state == S_RUN) && MemWrite;

    assign core_rst  = (state != S_RUN);
    assign done      = (state == S_DONE);

    assign inst      = ({1'b0, pc} < ld_count) ? imem[pc] : 9'h000;
    assign ReadData  = dmem[ALUOut];
    assign dbg_data  = dmem[dbg_addr];

    always_comb begin
        state_next    = state;
        ld_count_next = ld_count;
        halt_cnt_next = halt_cnt;
        case (state)
            S_LOAD: begin
                if (ld_accept) begin
                    ld_count_next = ld_count + 9'd1;
                    if (ld_final) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                halt_cnt_next = pc_repeat ? halt_cnt + 4'd1 : 4'd0;
                if (halt_hit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_LOAD;
            ld_count      <= 9'd0;
            halt_cnt      <= 4'd0;
            pc_prev       <= 8'd0;
            pc_prev_valid <= 1'b0;
        end else begin
            state    <= state_next;
            ld_count <= ld_count_next;
            halt_cnt <= halt_cnt_next;
            if (state == S_RUN) begin
                pc_prev       <= pc;
                pc_prev_valid <= 1'b1;
            end
        end
    end

    // Arrays carry no reset: a reset only rewinds ld_count, which masks stale words.
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            imem[ld_count[7:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[ALUOut] <= SrcA;
        end
    end

endmodule

// File: tb/tb_mem_system.sv
// Self-checking bench for mem_system: constant vector table, directed
// multi-cycle sequences and randomized dmem traffic against an array model.
module tb_mem_system;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [8:0] ld_data = 9'h000;
    logic       ld_last = 1'b0;
    logic [7:0] pc = 8'h00;
    logic [8:0] inst;
    logic       MemWrite = 1'b0;
    logic [7:0] ALUOut = 8'h00;
    logic [7:0] SrcA = 8'h00;
    logic [7:0] ReadData;
    logic       core_rst;
    logic       done;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    logic [8:0] ld_count;

    always #5 clk = ~clk;

    mem_system #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .HALT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .pc(pc), .inst(inst),
        .MemWrite(MemWrite), .ALUOut(ALUOut), .SrcA(SrcA), .ReadData(ReadData),
        .core_rst(core_rst), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .ld_count(ld_count)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: what was loaded, how many words count, what dmem holds.
    logic [8:0] imem_m [256];
    logic [7:0] dmem_m [256];
    int         ld_count_m = 0;

    typedef struct {
        logic [7:0] pc;
        logic [8:0] exp_inst;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] inst_m(input logic [7:0] p);
        return (int'(p) < ld_count_m) ? imem_m[p] : 9'h000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [8:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        imem_m[ld_count_m[7:0]] = d;
        ld_count_m++;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        ld_count_m = 0;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("load_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        logic [7:0] w;
        int         accepts;
        logic       m_load;
        logic       acc;
        logic [8:0] d;

        vecs[0] = '{8'h00, 9'h1A3};
        vecs[1] = '{8'h01, 9'h055};
        vecs[2] = '{8'h02, 9'h1FF};
        vecs[3] = '{8'h03, 9'h000};
        vecs[4] = '{8'h05, 9'h000};
        vecs[5] = '{8'hFF, 9'h000};

        // Test 1: three-word load, core release, inst masking
        tick();
        do_reset();
        load_word(9'h1A3, 1'b0);
        load_word(9'h055, 1'b0);
        chk("t1_core_rst_loading", 32'(core_rst), 32'd1);
        load_word(9'h1FF, 1'b1);
        chk("t1_ld_count", 32'(ld_count), 32'd3);
        chk("t1_core_rst_run", 32'(core_rst), 32'd0);
        chk("t1_ld_ready_run", 32'(ld_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            pc = vecs[i].pc;
            #1;
            chk($sformatf("t1_inst_pc%0h", vecs[i].pc), 32'(inst), 32'(vecs[i].exp_inst));
        end

        // Fill every dmem byte so later reads are fully defined
        for (int i = 0; i < 256; i++) begin
            pc       = 8'(i);
            ALUOut   = 8'(i);
            SrcA     = 8'($urandom);
            MemWrite = 1'b1;
            tick();
            dmem_m[i] = SrcA;
        end
        MemWrite = 1'b0;
        p = pc;

        // Randomized RUN traffic; pc never repeats back-to-back
        for (int i = 0; i < 150; i++) begin
            p        = p + 8'd1 + 8'($urandom_range(0, 253));
            pc       = p;
            MemWrite = 1'($urandom);
            ALUOut   = 8'($urandom);
            SrcA     = 8'($urandom);
            dbg_addr = 8'($urandom);
            #1;
            chk("rnd_readdata", 32'(ReadData), 32'(dmem_m[ALUOut]));
            chk("rnd_dbg_data", 32'(dbg_data), 32'(dmem_m[dbg_addr]));
            chk("rnd_inst", 32'(inst), 32'(inst_m(pc)));
            tick();
            if (MemWrite) dmem_m[ALUOut] = SrcA;
        end
        chk("rnd_done", 32'(done), 32'd0);

        // Test 2: write 8'hC3 to 8'h10, old value visible during the write cycle
        p        = p + 8'd1;
        pc       = p;
        ALUOut   = 8'h10;
        SrcA     = (dmem_m[8'h10] == 8'hC3) ? 8'h3C : 8'hC3;
        MemWrite = 1'b1;
        tick();
        dmem_m[8'h10] = SrcA;
        SrcA     = 8'hC3;
        p        = p + 8'd1;
        pc       = p;
        #1;
        chk("t2_rd_during_write", 32'(ReadData), 32'(dmem_m[8'h10]));
        tick();
        dmem_m[8'h10] = 8'hC3;
        MemWrite = 1'b0;
        p        = p + 8'd1;
        pc       = p;
        #1;
        chk("t2_rd_after_write", 32'(ReadData), 32'h0C3);

        // Test 6: pc ping-pong never halts
        for (int i = 0; i < 50; i++) begin
            pc = (i % 2 == 1) ? 8'h05 : 8'h04;
            tick();
        end
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_core_rst", 32'(core_rst), 32'd0);

        // Test 3: pc 0,1,2,2,2 halts; the halting cycle's write still lands
        pc = 8'h00; tick();
        pc = 8'h01; tick();
        pc = 8'h02; tick();
        pc = 8'h02; tick();
        chk("t3_done_early", 32'(done), 32'd0);
        pc       = 8'h02;
        MemWrite = 1'b1;
        ALUOut   = 8'h20;
        SrcA     = 8'h5A;
        tick();
        dmem_m[8'h20] = 8'h5A;
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_core_rst", 32'(core_rst), 32'd1);
        ALUOut   = 8'h10;
        SrcA     = 8'h00;
        tick();
        MemWrite = 1'b0;
        dbg_addr = 8'h10;
        #1;
        chk("t3_dbg_frozen", 32'(dbg_data), 32'h0C3);
        chk("t3_rd_frozen", 32'(ReadData), 32'h0C3);
        dbg_addr = 8'h20;
        #1;
        chk("t3_halt_cycle_write", 32'(dbg_data), 32'h05A);
        ld_valid = 1'b1;
        ld_data  = 9'h123;
        tick();
        ld_valid = 1'b0;
        chk("t3_ld_ignored", 32'(ld_count), 32'd3);
        pc = 8'h01;
        #1;
        chk("t3_inst_done", 32'(inst), 32'h055);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 8'($urandom);
            #1;
            chk("t3_dbg_readback", 32'(dbg_data), 32'(dmem_m[dbg_addr]));
        end

        // Test 5: reset mid-load, reload two words
        do_reset();
        for (int i = 0; i < 5; i++) load_word(9'($urandom), 1'b0);
        chk("t5_ld_count5", 32'(ld_count), 32'd5);
        rst = 1'b0;
        #1;
        ld_count_m = 0;
        chk("t5_rst_ld_count", 32'(ld_count), 32'd0);
        chk("t5_rst_core_rst", 32'(core_rst), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        load_word(9'h0AA, 1'b0);
        load_word(9'h155, 1'b1);
        chk("t5_ld_count", 32'(ld_count), 32'd2);
        chk("t5_core_rst", 32'(core_rst), 32'd0);
        pc = 8'h03;
        #1;
        chk("t5_inst_masked", 32'(inst), 32'(inst_m(8'h03)));
        pc = 8'h01;
        #1;
        chk("t5_inst_pc1", 32'(inst), 32'h155);
        chk("t5_done", 32'(done), 32'd0);

        // Test 4: 256-word stream, ld_valid every other cycle, no ld_last
        do_reset();
        accepts = 0;
        m_load  = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pc       = 8'(cyc);
            d        = 9'($urandom);
            ld_valid = (cyc % 2 == 0);
            ld_data  = d;
            ld_last  = 1'b0;
            acc      = ld_valid && m_load;
            tick();
            if (acc) begin
                imem_m[ld_count_m[7:0]] = d;
                ld_count_m++;
                accepts++;
                if (ld_count_m == 256) m_load = 1'b0;
            end
            if (cyc == 101) chk("t4_ld_count_mid", 32'(ld_count), 32'(ld_count_m));
        end
        ld_valid = 1'b0;
        chk("t4_ld_count", 32'(ld_count), 32'd256);
        chk("t4_core_rst", 32'(core_rst), 32'd0);
        chk("t4_ld_ready", 32'(ld_ready), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        pc = 8'hFF;
        #1;
        chk("t4_inst_last", 32'(inst), 32'(imem_m[255]));
        pc = 8'h00;
        #1;
        chk("t4_inst_first", 32'(inst), 32'(imem_m[0]));
        w = 8'h80;
        pc = w;
        #1;
        chk("t4_inst_mid", 32'(inst), 32'(imem_m[w]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_system.md
Name: mem_system

Overview:
- Memory-side responder for the single-cycle 8-bit core's instruction and data interfaces.
  - Serves 9-bit instructions by pc.
  - Serves and stores 8-bit data words on the core's MemWrite/ALUOut/SrcA/ReadData interface.
- A host streams the program into instruction memory over a valid/ready port while the block holds the core in reset.
- The block then releases the core and detects program halt (pc self-loop).
- After halt, it freezes data memory for host readback through a debug port.

Parameters:
- IMEM_DEPTH, 256, instruction words (9 bits each), addressed by 8-bit pc.
- DMEM_DEPTH, 256, data bytes, addressed by 8-bit ALUOut.
- HALT_CYCLES, 2, consecutive cycles of unchanged pc that declare halt (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- ld_valid  input  1  host presents a program word.
- ld_ready  output  1  block accepts a program word this cycle.
- ld_data  input  9  program word.
- ld_last  input  1  marks final program word (qualified by ld_valid & ld_ready).
- pc  input  8  core program counter.
- inst  output  9  instruction at pc.
- MemWrite  input  1  core data write enable.
- ALUOut  input  8  core data address.
- SrcA  input  8  core write data.
- ReadData  output  8  data at ALUOut.
- core_rst  output  1  active-high reset to the core.
- done  output  1  program halted; data memory frozen.
- dbg_addr  input  8  host readback address.
- dbg_data  output  8  dmem[dbg_addr].
- ld_count  output  9  number of instruction words loaded (0..256).

Behaviour:
- State machine: LOAD -> RUN -> DONE. DONE is exited only by rst.
- Reset (async assert, state held while rst=0):
  - State=LOAD, ld_count=0, halt counter=0, pc_prev_valid=0.
  - Outputs: core_rst=1, done=0, ld_ready=0 while rst=0.
  - Memory arrays are not cleared.
- LOAD:
  - ld_ready=1 and core_rst=1.
  - On each ld_valid & ld_ready: imem[ld_count] <= ld_data; ld_count <= ld_count+1.
  - Transition to RUN when the accepted word has ld_last=1, or when it is word index IMEM_DEPTH-1 (ld_count becomes 256; ld_last is ignored).
  - ld_valid=0 stalls indefinitely; there is no timeout.
  - Data memory is not writable in LOAD.
- RUN:
  - Outputs are registered from state: core_rst=0 starting the first cycle state==RUN; ld_ready=0.
  - inst is combinational: imem[pc] if pc < ld_count, else 9'h000.
  - ReadData is combinational: dmem[ALUOut].
  - dmem[ALUOut] <= SrcA on the rising edge when MemWrite=1. Read-during-write returns the old value in that cycle.
- Halt detection (RUN only):
  - Each cycle: pc_prev <= pc; pc_prev_valid <= 1.
  - If pc_prev_valid and pc==pc_prev: halt counter++, else counter=0.
  - When the counter reaches HALT_CYCLES, transition to DONE next edge. That cycle's MemWrite is still honoured.
- DONE:
  - core_rst=1, done=1, ld_ready=0.
  - MemWrite is ignored; dmem is frozen.
  - inst continues to follow its rule.
- Always valid in every state:
  - dbg_data = dmem[dbg_addr], combinational.
  - ReadData = dmem[ALUOut], combinational.
  - ld_count holds its last value.
- Loading zero words is impossible: the first accepted word always counts, even with ld_last=1.
- Reset mid-LOAD or mid-RUN:
  - Immediate return to LOAD, core_rst=1, ld_count=0.
  - Previously loaded imem contents persist but are masked by ld_count.
- A simultaneous ld_valid outside LOAD has no effect.

Test Plan:
1. Load 3 words 9'h1A3, 9'h055, 9'h1FF with ld_last on the 3rd -> ld_count=3; core_rst falls the cycle after the 3rd accept; inst at pc=1 is 9'h055 and at pc=5 is 9'h000.
2. In RUN, MemWrite=1, ALUOut=8'h10, SrcA=8'hC3 for one cycle -> ReadData at ALUOut=8'h10 is 8'hC3 the next cycle and the old value during the write cycle.
3. pc sequence 0,1,2,2,2 (HALT_CYCLES=2) -> done=1 and core_rst=1 on the edge after the second repeat. A later MemWrite to 8'h10 with 8'h00 leaves dbg_data(8'h10)=8'hC3.
4. Stream 256 words with ld_last never asserted, ld_valid toggling every other cycle -> exactly 256 accepts; ld_count=256; RUN entered; inst at pc=8'hFF equals the last word.
5. Assert rst low mid-load after 5 words, release, then load 2 words -> ld_count=2; inst at pc=3 is 9'h000; done=0.
6. pc alternating 4,5,4,5 for 50 cycles -> done stays 0; halt counter never reaches threshold.
